multicycle_ctrl: RTL

// Multi-cycle control sequencer for the MIPS-subset CPU datapath.

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/alu_op_decode.sv | 55 +++++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Shared encodings for the multi-cycle MIPS-subset control sequencer
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    c_st_reset  = 3'd0,
    c_st_fetch  = 3'd1,
    c_st_decode = 3'd2,
    c_st_exec   = 3'd3,
    c_st_mem    = 3'd4,
    c_st_wb     = 3'd5,
    c_st_trap   = 3'd6
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0A;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_srl  = 6'h02;
  localparam logic [5:0] c_fn_sra  = 6'h03;
  localparam logic [5:0] c_fn_jr   = 6'h08;
  localparam logic [5:0] c_fn_jalr = 6'h09;
  localparam logic [5:0] c_fn_add  = 6'h20;
  localparam logic [5:0] c_fn_addu = 6'h21;
  localparam logic [5:0] c_fn_sub  = 6'h22;
  localparam logic [5:0] c_fn_subu = 6'h23;
  localparam logic [5:0] c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or   = 6'h25;
  localparam logic [5:0] c_fn_xor  = 6'h26;
  localparam logic [5:0] c_fn_nor  = 6'h27;
  localparam logic [5:0] c_fn_slt  = 6'h2A;

  localparam logic [3:0] c_alu_and  = 4'b0000;
  localparam logic [3:0] c_alu_or   = 4'b0001;
  localparam logic [3:0] c_alu_addu = 4'b0010;
  localparam logic [3:0] c_alu_xor  = 4'b0011;
  localparam logic [3:0] c_alu_nor  = 4'b0100;
  localparam logic [3:0] c_alu_subu = 4'b0110;
  localparam logic [3:0] c_alu_slt  = 4'b0111;
  localparam logic [3:0] c_alu_sll  = 4'b1000;
  localparam logic [3:0] c_alu_srl  = 4'b1001;
  localparam logic [3:0] c_alu_sra  = 4'b1010;
  localparam logic [3:0] c_alu_add  = 4'b1011;
  localparam logic [3:0] c_alu_sub  = 4'b1110;

  localparam logic [1:0] c_pc_plus4  = 2'b00;
  localparam logic [1:0] c_pc_jump   = 2'b01;
  localparam logic [1:0] c_pc_branch = 2'b10;
  localparam logic [1:0] c_pc_reg    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// Module  : alu_op_decode
// Brief   : Maps {op, funct} to an ALU opcode and flags undecodable encodings
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_op,
  output logic       o_legal
);

  always_comb begin
    o_alu_op = c_alu_and;
    o_legal  = 1'b0;
    case (i_op)
      c_op_rtype: begin
        o_legal = 1'b1;
        case (i_funct)
          c_fn_sll:  o_alu_op = c_alu_sll;
          c_fn_srl:  o_alu_op = c_alu_srl;
          c_fn_sra:  o_alu_op = c_alu_sra;
          c_fn_jr:   o_alu_op = c_alu_addu;
          c_fn_jalr: o_alu_op = c_alu_addu;
          c_fn_add:  o_alu_op = c_alu_add;
          c_fn_addu: o_alu_op = c_alu_addu;
          c_fn_sub:  o_alu_op = c_alu_sub;
          c_fn_subu: o_alu_op = c_alu_subu;
          c_fn_and:  o_alu_op = c_alu_and;
          c_fn_or:   o_alu_op = c_alu_or;
          c_fn_xor:  o_alu_op = c_alu_xor;
          c_fn_nor:  o_alu_op = c_alu_nor;
          c_fn_slt:  o_alu_op = c_alu_slt;
          default:   o_legal  = 1'b0;
        endcase
      end
      c_op_j, c_op_jal:   o_legal = 1'b1;
      c_op_beq, c_op_bne: begin o_alu_op = c_alu_sub;  o_legal = 1'b1; end
      c_op_addi:          begin o_alu_op = c_alu_add;  o_legal = 1'b1; end
      c_op_addiu:         begin o_alu_op = c_alu_addu; o_legal = 1'b1; end
      c_op_slti:          begin o_alu_op = c_alu_slt;  o_legal = 1'b1; end
      c_op_andi:          begin o_alu_op = c_alu_and;  o_legal = 1'b1; end
      c_op_ori:           begin o_alu_op = c_alu_or;   o_legal = 1'b1; end
      c_op_lw, c_op_sw:   begin o_alu_op = c_alu_add;  o_legal = 1'b1; end
      default:            o_legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : FETCH/DECODE/EXEC/MEM/WB control FSM with memory wait timeout
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] ir_op,
  input  logic [5:0] ir_funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_wren,
  output logic       mem_addr_sel,
  output logic       ir_wren,
  output logic       pc_wren,
  output logic [1:0] pc_src,
  output logic       reg_file_wren,
  output logic       reg_file_dmux_sel,
  output logic       reg_file_rmux_sel,
  output logic       alu_mux_sel,
  output logic [3:0] alu_op,
  output logic       retire,
  output logic       trap,
  output logic       illegal_instr
);

  localparam logic [7:0] c_wait_last = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait;
  logic       r_illegal;

  logic [3:0] w_alu_op;
  logic       w_legal;
  logic       w_req_state;
  logic       w_stall;
  logic       w_timeout;
  logic       w_rtype;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_br;
  logic       w_is_jr;
  logic       w_is_jalr;

  alu_op_decode u_alu_op_decode (
    .i_op     (ir_op),
    .i_funct  (ir_funct),
    .o_alu_op (w_alu_op),
    .o_legal  (w_legal)
  );

  assign w_rtype     = (ir_op == c_op_rtype);
  assign w_is_lw     = (ir_op == c_op_lw);
  assign w_is_sw     = (ir_op == c_op_sw);
  assign w_is_br     = (ir_op == c_op_beq) || (ir_op == c_op_bne);
  assign w_is_jr     = w_rtype && (ir_funct == c_fn_jr);
  assign w_is_jalr   = w_rtype && (ir_funct == c_fn_jalr);
  assign w_req_state = (r_state == c_st_fetch) || (r_state == c_st_mem);
  assign w_stall     = w_req_state && !mem_ready;
  // A mem_ready on the limit cycle suppresses the timeout.
  assign w_timeout   = w_stall && (r_wait == c_wait_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_reset;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
    end else begin
      r_wait <= w_stall ? r_wait + 8'd1 : 8'd0;
      case (r_state)
        c_st_reset: r_state <= c_st_fetch;
        c_st_fetch: begin
          if (mem_ready)      r_state <= c_st_decode;
          else if (w_timeout) r_state <= c_st_trap;
        end
        c_st_decode: begin
          if (!w_legal) begin
            r_state   <= c_st_trap;
            r_illegal <= 1'b1;
          end else if ((ir_op == c_op_j) || (ir_op == c_op_jal)) begin
            r_state <= c_st_fetch;
          end else begin
            r_state <= c_st_exec;
          end
        end
        c_st_exec: begin
          if (w_is_br || w_is_jr || w_is_jalr) r_state <= c_st_fetch;
          else if (w_is_lw || w_is_sw)         r_state <= c_st_mem;
          else                                 r_state <= c_st_wb;
        end
        c_st_mem: begin
          if (mem_ready)      r_state <= w_is_sw ? c_st_fetch : c_st_wb;
          else if (w_timeout) r_state <= c_st_trap;
        end
        c_st_wb:   r_state <= c_st_fetch;
        c_st_trap: r_state <= c_st_trap;
        default:   r_state <= c_st_reset;
      endcase
    end
  end

  // Outputs follow the state directly so reset removes them without a clock.
  always_comb begin
    mem_req           = 1'b0;
    mem_wren          = 1'b0;
    mem_addr_sel      = 1'b0;
    ir_wren           = 1'b0;
    pc_wren           = 1'b0;
    pc_src            = c_pc_plus4;
    reg_file_wren     = 1'b0;
    reg_file_dmux_sel = 1'b0;
    reg_file_rmux_sel = 1'b0;
    alu_mux_sel       = 1'b0;
    alu_op            = c_alu_and;
    retire            = 1'b0;
    trap              = (r_state == c_st_trap);
    illegal_instr     = r_illegal;
    case (r_state)
      c_st_fetch: begin
        alu_mux_sel = w_rtype;
        mem_req     = 1'b1;
        ir_wren     = mem_ready;
        pc_wren     = mem_ready;
      end
      c_st_decode: begin
        alu_mux_sel = w_rtype;
        if (ir_op == c_op_j || ir_op == c_op_jal) begin
          pc_wren       = 1'b1;
          pc_src        = c_pc_jump;
          retire        = 1'b1;
          reg_file_wren = (ir_op == c_op_jal);
        end
      end
      c_st_exec: begin
        alu_mux_sel = w_rtype;
        alu_op      = w_alu_op;
        if (w_is_br) begin
          pc_wren = (ir_op == c_op_beq) ? alu_zero : !alu_zero;
          pc_src  = c_pc_branch;
          retire  = 1'b1;
        end else if (w_is_jr || w_is_jalr) begin
          pc_wren       = 1'b1;
          pc_src        = c_pc_reg;
          retire        = 1'b1;
          reg_file_wren = w_is_jalr;
        end
      end
      c_st_mem: begin
        alu_mux_sel  = w_rtype;
        alu_op       = c_alu_add;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_wren     = w_is_sw;
        retire       = mem_ready && w_is_sw;
      end
      c_st_wb: begin
        alu_mux_sel       = w_rtype;
        reg_file_wren     = 1'b1;
        reg_file_dmux_sel = !w_is_lw;
        reg_file_rmux_sel = w_rtype;
        retire            = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
